// File: rtl/imm_enc_pkg.sv
// imm_enc_pkg: shared definitions for the immediate encoder and any
// decoder-side checker that wants the same RV32I field layouts.
//   - op_e    : symbolic request operation (LI, LW, SW, LA)
//   - state_e : encoder sequencing states
//   - fmt_e   : instruction format selector for imm_enc_fmt
//   - opcode / funct3 constants and packed R/I/S/U field structs
//   - split_hi: upper 20 bits of a constant, compensated for the sign of lo
package imm_enc_pkg;

  typedef enum logic [1:0] {
    OP_LI = 2'b00,
    OP_LW = 2'b01,
    OP_SW = 2'b10,
    OP_LA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT1 = 2'd1,
    ST_EMIT2 = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_S = 2'd2,
    FMT_U = 2'd3
  } fmt_e;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_W    = 3'b010;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_type_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } s_type_t;

  typedef struct packed {
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } u_type_t;

  // ADDI sign-extends lo, so hi absorbs one extra unit when lo is negative.
  // The sum wraps mod 2^20 on purpose (e.g. 0xFFFFF800 -> hi 0).
  function automatic logic [19:0] split_hi(input logic [31:0] value);
    return value[31:12] + {19'd0, value[11]};
  endfunction

  // True when value is representable as a signed 12-bit offset.
  function automatic logic fits_simm12(input logic [31:0] value);
    return (&value[31:11]) | ~(|value[31:11]);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request and instruction-output streams of imm_encoder.
//   request : req_valid/req_ready, req_op, req_rd, req_rs1, req_rs2, req_value
//   output  : out_valid/out_ready, out_ins, out_last
//   status  : err (one-cycle rejection pulse)
// master = request producer / word consumer, slave = the encoder.
interface imm_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic        out_last;
  logic        err;

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_value, out_ready,
    input  req_ready, out_valid, out_ins, out_last, err
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_value, out_ready,
    output req_ready, out_valid, out_ins, out_last, err
  );
endinterface

// File: rtl/imm_enc_fmt.sv
// imm_enc_fmt: combinational RV32I word packer.
//   fmt_i    : R/I/S/U layout select
//   opcode_i : 7-bit major opcode
//   funct3_i : funct3 field (ignored for U)
//   rd_i, rs1_i, rs2_i : register fields
//   imm_i    : immediate; I/S use [11:0], U uses [31:12], R takes funct7 from [31:25]
//   ins_o    : assembled 32-bit instruction
module imm_enc_fmt
  import imm_enc_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] ins_o
);

  r_type_t r_word;
  i_type_t i_word;
  s_type_t s_word;
  u_type_t u_word;

  always_comb begin
    r_word = '{funct7: imm_i[31:25], rs2: rs2_i, rs1: rs1_i, funct3: funct3_i,
               rd: rd_i, opcode: opcode_i};
    i_word = '{imm: imm_i[11:0], rs1: rs1_i, funct3: funct3_i, rd: rd_i,
               opcode: opcode_i};
    s_word = '{imm_hi: imm_i[11:5], rs2: rs2_i, rs1: rs1_i, funct3: funct3_i,
               imm_lo: imm_i[4:0], opcode: opcode_i};
    u_word = '{imm: imm_i[31:12], rd: rd_i, opcode: opcode_i};

    ins_o = '0;
    case (fmt_i)
      FMT_R:   ins_o = r_word;
      FMT_I:   ins_o = i_word;
      FMT_S:   ins_o = s_word;
      FMT_U:   ins_o = u_word;
      default: ins_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: turns a symbolic request (LI/LW/SW/LA + registers + 32-bit
// value) into one or two RV32I words on a valid/ready stream.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : imm_encoder_if.slave (request stream in, instruction stream out,
//           err pulse)
// Build option IMMENC_RANGE_CHK_EN: LW/SW offsets outside [-2048, 2047] are
// rejected with a one-cycle err pulse instead of being truncated.
module imm_encoder
  import imm_enc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  imm_encoder_if.slave bus
);

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_ins_q, out_ins_d;
  logic        out_last_q, out_last_d;
  // The first word is fully captured into out_ins_q at accept; only what the
  // trailing ADDI needs is kept from the request.
  logic [4:0]  rd_q, rd_d;
  logic [11:0] lo_q, lo_d;
  logic        two_q, two_d;

  op_e         req_op;
  logic [19:0] req_hi;
  logic [11:0] req_lo;
  logic        req_two;
  logic        accept;
  logic        xfer;
  logic        reject;

  fmt_e        fmt_sel;
  logic [6:0]  fmt_opc;
  logic [2:0]  fmt_f3;
  logic [4:0]  fmt_rd;
  logic [4:0]  fmt_rs1;
  logic [31:0] fmt_imm;
  logic [31:0] fmt_word;

  assign req_op  = op_e'(bus.req_op);
  assign req_lo  = bus.req_value[11:0];
  assign req_hi  = split_hi(bus.req_value);
  assign req_two = (req_op == OP_LA) ||
                   ((req_op == OP_LI) && (req_hi != 20'd0) && (req_lo != 12'd0));
  assign accept  = bus.req_valid && (state_q == ST_IDLE);
  assign xfer    = out_valid_q && bus.out_ready;

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_ins   = out_ins_q;
  assign bus.out_last  = out_last_q;

`ifdef IMMENC_RANGE_CHK_EN
  logic err_q;

  assign reject  = ((req_op == OP_LW) || (req_op == OP_SW)) &&
                   !fits_simm12(bus.req_value);
  assign bus.err = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept && reject;
  end
`else
  assign reject  = 1'b0;
  assign bus.err = 1'b0;
`endif

  // Formatter operands: in IDLE they describe the first word of the incoming
  // request; afterwards they describe the trailing ADDI rd,rd,lo.
  always_comb begin
    fmt_sel = FMT_I;
    fmt_opc = OPC_OPIMM;
    fmt_f3  = F3_ADDI;
    fmt_rd  = bus.req_rd;
    fmt_rs1 = 5'd0;
    fmt_imm = {{20{req_lo[11]}}, req_lo};
    if (state_q != ST_IDLE) begin
      fmt_rd  = rd_q;
      fmt_rs1 = rd_q;
      fmt_imm = {{20{lo_q[11]}}, lo_q};
    end else begin
      case (req_op)
        OP_LI: begin
          // hi == 0 keeps the ADDI rd,x0,lo default
          if (req_hi != 20'd0) begin
            fmt_sel = FMT_U;
            fmt_opc = OPC_LUI;
            fmt_imm = {req_hi, 12'h000};
          end
        end
        OP_LA: begin
          fmt_sel = FMT_U;
          fmt_opc = OPC_AUIPC;
          fmt_imm = {req_hi, 12'h000};
        end
        OP_LW: begin
          fmt_opc = OPC_LOAD;
          fmt_f3  = F3_W;
          fmt_rs1 = bus.req_rs1;
        end
        OP_SW: begin
          fmt_sel = FMT_S;
          fmt_opc = OPC_STORE;
          fmt_f3  = F3_W;
          fmt_rs1 = bus.req_rs1;
        end
        default: ;
      endcase
    end
  end

  imm_enc_fmt u_fmt (
    .fmt_i    (fmt_sel),
    .opcode_i (fmt_opc),
    .funct3_i (fmt_f3),
    .rd_i     (fmt_rd),
    .rs1_i    (fmt_rs1),
    .rs2_i    (bus.req_rs2),
    .imm_i    (fmt_imm),
    .ins_o    (fmt_word)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_ins_d   = out_ins_q;
    out_last_d  = out_last_q;
    rd_d        = rd_q;
    lo_d        = lo_q;
    two_d       = two_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && !reject) begin
          rd_d        = bus.req_rd;
          lo_d        = req_lo;
          two_d       = req_two;
          state_d     = ST_EMIT1;
          out_valid_d = 1'b1;
          out_ins_d   = fmt_word;
          out_last_d  = !req_two;
        end
      end
      ST_EMIT1: begin
        if (xfer) begin
          if (two_q) begin
            state_d    = ST_EMIT2;
            out_ins_d  = fmt_word;
            out_last_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
      end
      ST_EMIT2: begin
        if (xfer) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_ins_q   <= '0;
      out_last_q  <= 1'b0;
      rd_q        <= '0;
      lo_q        <= '0;
      two_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_ins_q   <= out_ins_d;
      out_last_q  <= out_last_d;
      rd_q        <= rd_d;
      lo_q        <= lo_d;
      two_q       <= two_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed bench for imm_encoder with a
// behavioural RV32I encoding model. Honours IMMENC_RANGE_CHK_EN like the RTL.
module tb_imm_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  imm_encoder_if bus ();

  imm_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          l0;
    bit          l1;
    bit          err_seen;
    bit          tmo;
    bit          rdy_after;
    int          lat;
    int          unstable;
    int          first_xfer;
  } res_t;

  // Reference: value = hi*4096 + signext(lo), hi found by rounding to nearest.
  function automatic void model(input logic [1:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] v, output int n,
                                output logic [31:0] w0, output logic [31:0] w1,
                                output bit e);
    logic [31:0] lo, hi, r, s1, s2;
    lo = v & 32'hFFF;
    hi = (v + 32'h800) >> 12;
    r = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2);
    n = 1; w0 = 0; w1 = 0; e = 0;
    case (op)
      2'd0: begin
        if (hi == 0)      w0 = (lo << 20) | (r << 7) | 32'h13;
        else if (lo == 0) w0 = (hi << 12) | (r << 7) | 32'h37;
        else begin
          n = 2;
          w0 = (hi << 12) | (r << 7) | 32'h37;
          w1 = (lo << 20) | (r << 15) | (r << 7) | 32'h13;
        end
      end
      2'd1: w0 = (lo << 20) | (s1 << 15) | (32'd2 << 12) | (r << 7) | 32'h03;
      2'd2: w0 = ((lo >> 5) << 25) | (s2 << 20) | (s1 << 15) | (32'd2 << 12) |
                 ((lo & 32'h1F) << 7) | 32'h23;
      default: begin
        n = 2;
        w0 = (hi << 12) | (r << 7) | 32'h17;
        w1 = (lo << 20) | (r << 15) | (r << 7) | 32'h13;
      end
    endcase
`ifdef IMMENC_RANGE_CHK_EN
    if ((op == 2'd1 || op == 2'd2) && ($signed(v) < -2048 || $signed(v) > 2047)) begin
      n = 0; w0 = 0; e = 1;
    end
`endif
  endfunction

  // Drives one request and collects the resulting words.
  // mode 0: out_ready always 1; 1: random; 2: low for the first 3 cycles.
  task automatic run_req(input logic [1:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] val, input int mode, output res_t r);
    int k, cyc, cd;
    bit prev_stall, done;
    logic [31:0] prev_ins;
    logic prev_last;
    r = '{nw: 0, w0: 0, w1: 0, l0: 0, l1: 0, err_seen: 0, tmo: 0, rdy_after: 0,
          lat: -1, unstable: 0, first_xfer: -1};
    k = 0;
    @(negedge clk);
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    if (!bus.req_ready) begin r.tmo = 1; return; end
    bus.req_valid = 1; bus.req_op = op; bus.req_rd = rd; bus.req_rs1 = rs1;
    bus.req_rs2 = rs2; bus.req_value = val; bus.out_ready = 0;
    @(posedge clk); #1;
    // scramble inputs to show the latched request is used
    bus.req_valid = 0; bus.req_op = 2'($urandom); bus.req_rd = 5'($urandom);
    bus.req_rs1 = 5'($urandom); bus.req_rs2 = 5'($urandom); bus.req_value = $urandom;
    cyc = 0; cd = -1; done = 0; prev_stall = 0; prev_ins = 0; prev_last = 0;
    while (!done && cyc < 40) begin
      @(negedge clk); cyc++;
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (cyc > 3);
      endcase
      if (bus.out_valid && r.lat < 0) r.lat = cyc;
      if (prev_stall && (bus.out_ins !== prev_ins || bus.out_last !== prev_last ||
                         bus.out_valid !== 1'b1)) r.unstable++;
      if (bus.err === 1'b1) begin r.err_seen = 1; if (cd < 0) cd = 3; end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_ins = bus.out_ins; prev_last = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        if (r.nw == 0) begin r.w0 = bus.out_ins; r.l0 = bus.out_last; r.first_xfer = cyc; end
        else if (r.nw == 1) begin r.w1 = bus.out_ins; r.l1 = bus.out_last; end
        r.nw++;
        if (bus.out_last) begin
          @(negedge clk);
          r.rdy_after = bus.req_ready && !bus.out_valid;
          done = 1;
        end
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin done = 1; r.rdy_after = bus.req_ready; end
      end
    end
    bus.out_ready = 0;
    if (!done) r.tmo = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; bus.req_valid = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_ins !== 32'h0) begin n_bad++; $display("FAIL reset_out_ins got %h want 0", bus.out_ins); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.err); end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    $display("txn reset done");
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1};
    logic [4:0]  t_rd [6] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd10, 5'd4};
    logic [31:0] t_v  [6] = '{32'h12345FFF, 32'd5, 32'h10000000, 32'hFFFFF800, 32'h00001800, 32'h800};
    int          t_n  [6] = '{2, 1, 1, 1, 2, 1};
    logic [31:0] t_w0 [6] = '{32'h123462B7, 32'h00500093, 32'h10000137, 32'h80000193, 32'h00002517, 32'h80012203};
    logic [31:0] t_w1 [6] = '{32'hFFF28293, 32'h0, 32'h0, 32'h0, 32'h80050513, 32'h0};
    bit          t_e  [6] = '{0, 0, 0, 0, 0, 0};
    res_t r;
`ifdef IMMENC_RANGE_CHK_EN
    t_n[5] = 0; t_e[5] = 1;
`endif
    for (int i = 0; i < 6; i++) begin
      run_req(t_op[i], t_rd[i], 5'd2, 5'd0, t_v[i], 0, r);
      $display("txn directed %0d op=%0d val=%h words=%0d w0=%h w1=%h err=%0b", i, t_op[i], t_v[i], r.nw, r.w0, r.w1, r.err_seen);
      n_cmp++; if (r.tmo || r.nw != t_n[i]) begin n_bad++; $display("FAIL dir%0d_count got %0d (tmo %0b) want %0d", i, r.nw, r.tmo, t_n[i]); end
      n_cmp++; if (r.err_seen != t_e[i]) begin n_bad++; $display("FAIL dir%0d_err got %0b want %0b", i, r.err_seen, t_e[i]); end
      n_cmp++; if (r.rdy_after !== 1'b1) begin n_bad++; $display("FAIL dir%0d_ready_after got %0b want 1", i, r.rdy_after); end
      if (t_n[i] >= 1) begin
        n_cmp++; if (r.w0 !== t_w0[i]) begin n_bad++; $display("FAIL dir%0d_w0 got %h want %h", i, r.w0, t_w0[i]); end
        n_cmp++; if (r.l0 != (t_n[i] == 1)) begin n_bad++; $display("FAIL dir%0d_last0 got %0b want %0b", i, r.l0, t_n[i] == 1); end
        n_cmp++; if (r.lat != 1) begin n_bad++; $display("FAIL dir%0d_latency got %0d want 1", i, r.lat); end
      end
      if (t_n[i] == 2) begin
        n_cmp++; if (r.w1 !== t_w1[i] || r.l1 != 1'b1) begin n_bad++; $display("FAIL dir%0d_w1 got %h/%0b want %h/1", i, r.w1, r.l1, t_w1[i]); end
      end
    end
  endtask

  task automatic test_stall();
    res_t r;
    run_req(2'd2, 5'd0, 5'd2, 5'd6, 32'd8, 2, r);
    $display("txn stall SW words=%0d w0=%h xfer_cycle=%0d", r.nw, r.w0, r.first_xfer);
    n_cmp++; if (r.tmo || r.nw != 1 || r.w0 !== 32'h00612423) begin n_bad++; $display("FAIL stall_word got %h n=%0d want 00612423 n=1", r.w0, r.nw); end
    n_cmp++; if (r.unstable != 0) begin n_bad++; $display("FAIL stall_hold got %0d changes want 0", r.unstable); end
    n_cmp++; if (r.first_xfer != 4 || r.lat != 1) begin n_bad++; $display("FAIL stall_timing got xfer %0d lat %0d want 4 1", r.first_xfer, r.lat); end
    n_cmp++; if (r.l0 !== 1'b1 || r.rdy_after !== 1'b1) begin n_bad++; $display("FAIL stall_last got last %0b rdy %0b want 1 1", r.l0, r.rdy_after); end
  endtask

  task automatic run_checked(input string tag, input int idx, input int mode);
    logic [1:0] op; logic [4:0] rd, rs1, rs2; logic [31:0] v;
    int en; logic [31:0] e0, e1; bit ee; res_t r;
    op = 2'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    case ($urandom_range(0, 5))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 4095)) - 32'd2048;
      2: v = $urandom & 32'hFFFFF000;
      3: v = 32'hFFFFF800 + 32'($urandom_range(0, 2047));
      4: v = ($urandom & 32'hFFFFF000) | 32'h800;
      default: v = 32'($urandom_range(0, 4095));
    endcase
    model(op, rd, rs1, rs2, v, en, e0, e1, ee);
    run_req(op, rd, rs1, rs2, v, mode, r);
    $display("txn %s %0d op=%0d rd=%0d rs1=%0d rs2=%0d val=%h words=%0d w0=%h w1=%h err=%0b",
             tag, idx, op, rd, rs1, rs2, v, r.nw, r.w0, r.w1, r.err_seen);
    n_cmp++; if (r.tmo || r.nw != en) begin n_bad++; $display("FAIL %s%0d_count got %0d (tmo %0b) want %0d", tag, idx, r.nw, r.tmo, en); end
    n_cmp++; if (r.err_seen != ee) begin n_bad++; $display("FAIL %s%0d_err got %0b want %0b", tag, idx, r.err_seen, ee); end
    n_cmp++; if (r.unstable != 0) begin n_bad++; $display("FAIL %s%0d_hold got %0d want 0", tag, idx, r.unstable); end
    n_cmp++; if (r.rdy_after !== 1'b1) begin n_bad++; $display("FAIL %s%0d_ready_after got %0b want 1", tag, idx, r.rdy_after); end
    n_cmp++; if (r.lat != ((en > 0) ? 1 : -1)) begin n_bad++; $display("FAIL %s%0d_latency got %0d want %0d", tag, idx, r.lat, (en > 0) ? 1 : -1); end
    if (en >= 1) begin
      n_cmp++; if (r.w0 !== e0 || r.l0 != (en == 1)) begin n_bad++; $display("FAIL %s%0d_w0 got %h/%0b want %h/%0b", tag, idx, r.w0, r.l0, e0, en == 1); end
    end
    if (en == 2) begin
      n_cmp++; if (r.w1 !== e1 || r.l1 != 1'b1) begin n_bad++; $display("FAIL %s%0d_w1 got %h/%0b want %h/1", tag, idx, r.w1, r.l1, e1); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) run_checked("rand", i, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) run_checked("b2b", i, 0);
  endtask

  task automatic test_reset_mid();
    res_t r;
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    bus.req_valid = 1; bus.req_op = 2'd3; bus.req_rd = 5'd10; bus.req_value = 32'h1800;
    bus.out_ready = 1;
    @(posedge clk); #1 bus.req_valid = 0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ins !== 32'h00002517) begin n_bad++; $display("FAIL rstmid_first got %b/%h want 1/00002517", bus.out_valid, bus.out_ins); end
    @(posedge clk); #1 bus.out_ready = 0; rst_n = 0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ins !== 32'h80050513) begin n_bad++; $display("FAIL rstmid_second got %b/%h want 1/80050513", bus.out_valid, bus.out_ins); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_ins !== 32'h0 || bus.out_last !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL rstmid_outputs got %h/%b/%b want 0/0/0", bus.out_ins, bus.out_last, bus.err); end
    @(posedge clk); #1 rst_n = 1;
    run_req(2'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0, r);
    $display("txn reset_mid recovery words=%0d w0=%h", r.nw, r.w0);
    n_cmp++; if (r.tmo || r.nw != 1 || r.w0 !== 32'h00500093 || r.l0 !== 1'b1) begin n_bad++; $display("FAIL rstmid_recover got %h n=%0d want 00500093 n=1", r.w0, r.nw); end
  endtask

  initial begin
    bus.req_valid = 0; bus.req_op = 0; bus.req_rd = 0; bus.req_rs1 = 0;
    bus.req_rs2 = 0; bus.req_value = 0; bus.out_ready = 0;
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Instruction-word builder: the encode direction of the decoder's immediate generation. It accepts a symbolic request (operation, registers, 32-bit value) and emits one or two RV32I instruction words on a valid/ready stream. Sits between the UART boot/debug command path and the instruction-memory write port, so host-side constants and loads/stores are materialised as legal machine code on chip.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  2  00 LI (load immediate), 01 LW, 10 SW, 11 LA (pc-relative address)
- req_rd  in  5  destination register (LI, LW, LA)
- req_rs1  in  5  base register (LW, SW)
- req_rs2  in  5  store data register (SW)
- req_value  in  32  constant (LI), byte offset (LW/SW/LA)
- out_valid  out  1  out_ins holds a word
- out_ready  in  1  consumer takes word
- out_ins  out  32  encoded instruction
- out_last  out  1  out_ins is the final word of the current request
- err  out  1  one-cycle pulse: request rejected (range-check build only)

## Operation
- States: IDLE, EMIT1, EMIT2. req_ready = (state == IDLE).
- Accept on req_valid && req_ready. All request fields are registered; later input changes are ignored.
- Split: lo = value[11:0]; hi = value[31:12] + value[11], 20-bit and wrapping mod 2^20.
- LI:
  - If hi == 0: one word, ADDI rd,x0,lo.
  - Else if lo == 0: one word, LUI rd,hi.
  - Else: two words, LUI rd,hi then ADDI rd,rd,lo.
- LA: always two words, AUIPC rd,hi then ADDI rd,rd,lo.
- LW: one word, I-type: lo in [31:20], rs1, funct3 010, rd, opcode 0000011.
- SW: one word, S-type: lo[11:5] in [31:25], rs2, rs1, funct3 010, lo[4:0] in [11:7], opcode 0100011.
- Opcodes: LUI 0110111, AUIPC 0010111, ADDI 0010011 with funct3 000.
- Transitions:
  - IDLE -> EMIT1 on accept.
  - EMIT1 -> EMIT2 on handshake when the request needs two words.
  - EMIT1 -> IDLE on handshake when it needs one word.
  - EMIT2 -> IDLE on handshake.

## Timing
- Reset values: state IDLE, out_valid 0, out_ins 0, out_last 0, err 0. req_ready reads 1 in the first cycle after reset deasserts.
- Latency: out_valid rises the cycle after accept. All outputs are registered.
- Handshake:
  - out_ins and out_last are held stable while out_valid && !out_ready.
  - A word transfers on out_valid && out_ready.
  - A second word appears the cycle after the first word transfers.
- After the last word transfers, out_valid drops and req_ready is 1 in the next cycle. No same-cycle request overlap.
- Throughput: one request per (words + 1) cycles minimum.
- out_last is 1 on the single word of a one-word request and on the second word of a two-word request.
- Reset asserted mid-request: request abandoned, outputs take reset values on that edge, no partial word is held.
- hi wrap example: value 0xFFFFF800 gives hi = 0, so LI emits a single ADDI rd,x0,-2048.

## Configuration
- IMMENC_RANGE_CHK_EN
  - Defined: an LW/SW whose req_value is outside the signed 12-bit range [-2048, 2047] is accepted but not encoded. err pulses one cycle after accept, state returns to IDLE, and out_valid stays 0.
  - Undefined: err is tied to 0 and the offset is silently truncated to value[11:0].
- LI and LA are never range-checked.

## Structure
- Shared package imm_enc_pkg holds:
  - op enum (OP_LI, OP_LW, OP_SW, OP_LA) and the state enum;
  - 7-bit opcode constants and funct3 constants;
  - the packed R/I/S/U field-layout structs, also usable by decoder-side checkers.
- One sub-module, imm_enc_fmt: combinational, takes {format, rd, rs1, rs2, imm32} and returns the 32-bit word.
- The FSM, the hi/lo split and the word sequencing stay in imm_encoder.

## Test plan
- LI x5, 0x12345FFF, out_ready held 1 -> 0x123462B7 (out_last 0), then 0xFFF28293 (out_last 1); req_ready returns 1 the following cycle.
- LI x1, 5 -> single word 0x00500093 with out_last 1. LI x2, 0x10000000 -> single word 0x10000137. LI x3, 0xFFFFF800 -> single word 0x80000193.
- SW rs2=x6, rs1=x2, value 8, with out_ready low for 3 cycles -> out_ins holds 0x00612423 for all stalled cycles and transfers on the first out_ready cycle.
- LA x10, 0x00001800 -> AUIPC 0x00002517, then ADDI 0x80050513.
- LW rd=x4, rs1=x2, value 0x800: with IMMENC_RANGE_CHK_EN -> err pulse, no output word; without it -> word 0x80012203.
- rst_n low while in EMIT2 after the first LA word -> out_valid 0 on that edge, out_ins/out_last/err at reset values; a new LI x1,5 afterwards emits 0x00500093 normally.
